// File: rtl/ft_lockstep_ctrl.sv
// Lockstep comparator and recovery sequencer for 2 or 3 replicated cores.
// Compares register-file writes, checkpoints retired PCs and drives core reset/restore.
module ft_lockstep_ctrl #(
    parameter int NCORES    = 2,
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int CNT_W     = 8,
    parameter int MAX_RETRY = 3,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic [NCORES-1:0]        we_i,
    input  logic [NCORES*ADDR_W-1:0] addr_i,
    input  logic [NCORES*DATA_W-1:0] data_i,
    input  logic [PC_W-1:0]          pc_i,
    input  logic                     commit_i,
    input  logic                     done_i,
    output logic                     reset_o,
    output logic                     recover_o,
    output logic [PC_W-1:0]          recovery_pc_o,
    output logic                     error_o,
    output logic [NCORES-1:0]        faulty_o,
    output logic [CNT_W-1:0]         err_count_o
);
    localparam int TUP_W   = 1 + ADDR_W + DATA_W;
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {ST_RUN, ST_RST, ST_RECOVER, ST_FAIL} state_t;

    state_t             state_reg;
    logic               reset_reg;
    logic               recover_reg;
    logic               error_reg;
    logic [PC_W-1:0]    ckpt_reg;
    logic [NCORES-1:0]  faulty_reg;
    logic [CNT_W-1:0]   err_count_reg;
    logic [RETRY_W-1:0] retry_reg;

    logic [TUP_W-1:0]   tuple [NCORES];
    logic [NCORES-1:0]  we_diff;
    logic [NCORES-1:0]  ad_diff;
    logic [NCORES-1:0]  dissent;
    logic               mismatch;

    // Each core's write is reduced to one tuple; differences are taken against core 0.
    genvar gi;
    generate
        for (gi = 0; gi < NCORES; gi++) begin : g_core
            assign tuple[gi]   = {we_i[gi], addr_i[gi*ADDR_W +: ADDR_W], data_i[gi*DATA_W +: DATA_W]};
            assign we_diff[gi] = we_i[gi] != we_i[0];
            assign ad_diff[gi] = tuple[gi][TUP_W-2:0] != tuple[0][TUP_W-2:0];
        end
    endgenerate

    assign mismatch = (state_reg == ST_RUN) && enable_i &&
                      ((|we_diff) || ((&we_i) && (|ad_diff)));

    // With three cores the odd one out is blamed; without a majority every core is.
    generate
        if (NCORES == 3) begin : g_vote
            always_comb begin
                dissent = 3'b111;
                if (tuple[0] == tuple[1])
                    dissent = 3'b100;
                else if (tuple[0] == tuple[2])
                    dissent = 3'b010;
                else if (tuple[1] == tuple[2])
                    dissent = 3'b001;
            end
        end else begin : g_pair
            assign dissent = '1;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= ST_RUN;
            reset_reg     <= 1'b0;
            recover_reg   <= 1'b0;
            error_reg     <= 1'b0;
            ckpt_reg      <= RESET_PC;
            faulty_reg    <= '0;
            err_count_reg <= '0;
            retry_reg     <= '0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (mismatch) begin
                        faulty_reg <= faulty_reg | dissent;
                        if (err_count_reg != {CNT_W{1'b1}})
                            err_count_reg <= err_count_reg + 1'b1;
                        if (retry_reg == RETRY_W'(MAX_RETRY)) begin
                            state_reg <= ST_FAIL;
                            error_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_RST;
                            reset_reg <= 1'b1;
                            retry_reg <= retry_reg + 1'b1;
                        end
                    end else if (enable_i && commit_i) begin
                        ckpt_reg  <= pc_i;
                        retry_reg <= '0;
                    end
                end
                ST_RST: begin
                    state_reg   <= ST_RECOVER;
                    reset_reg   <= 1'b0;
                    recover_reg <= 1'b1;
                end
                ST_RECOVER: begin
                    if (done_i) begin
                        state_reg   <= ST_RUN;
                        recover_reg <= 1'b0;
                    end
                end
                ST_FAIL: begin
                    state_reg <= ST_FAIL;
                end
                default: begin
                    state_reg <= ST_RUN;
                end
            endcase
        end
    end

    assign reset_o       = reset_reg;
    assign recover_o     = recover_reg;
    assign error_o       = error_reg;
    assign recovery_pc_o = ckpt_reg;
    assign faulty_o      = faulty_reg;
    assign err_count_o   = err_count_reg;
endmodule

// File: tb/tb_ft_lockstep_ctrl.sv
// Bench for ft_lockstep_ctrl: a 2-core and a 3-core instance share control inputs
// and are checked every cycle against a behavioural model of the recovery rules.
module tb_ft_lockstep_ctrl;
    localparam int MAX_RETRY = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, enable, commit, done;
    logic [31:0] pc;
    logic        cwe   [2][3];
    logic [5:0]  caddr [2][3];
    logic [31:0] cdata [2][3];

    logic [1:0]  we2;   logic [11:0] addr2; logic [63:0] data2;
    logic [2:0]  we3;   logic [17:0] addr3; logic [95:0] data3;
    assign we2   = {cwe[0][1], cwe[0][0]};
    assign addr2 = {caddr[0][1], caddr[0][0]};
    assign data2 = {cdata[0][1], cdata[0][0]};
    assign we3   = {cwe[1][2], cwe[1][1], cwe[1][0]};
    assign addr3 = {caddr[1][2], caddr[1][1], caddr[1][0]};
    assign data3 = {cdata[1][2], cdata[1][1], cdata[1][0]};

    logic r2, v2, e2, r3, v3, e3;
    logic [31:0] p2, p3;
    logic [1:0] f2;
    logic [2:0] f3;
    logic [7:0] c2, c3;

    ft_lockstep_ctrl #(.NCORES(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .we_i(we2), .addr_i(addr2),
        .data_i(data2), .pc_i(pc), .commit_i(commit), .done_i(done), .reset_o(r2),
        .recover_o(v2), .recovery_pc_o(p2), .error_o(e2), .faulty_o(f2), .err_count_o(c2));

    ft_lockstep_ctrl #(.NCORES(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .we_i(we3), .addr_i(addr3),
        .data_i(data3), .pc_i(pc), .commit_i(commit), .done_i(done), .reset_o(r3),
        .recover_o(v3), .recovery_pc_o(p3), .error_o(e3), .faulty_o(f3), .err_count_o(c3));

    // Model: phase 0=RUN 1=RST 2=RECOVER 3=FAIL, per instance.
    int          m_phase  [2];
    logic [31:0] m_ckpt   [2];
    int          m_retry  [2];
    int          m_cnt    [2];
    logic [2:0]  m_faulty [2];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] blame(int i, int n);
        logic [38:0] t [3];
        logic [38:0] maj;
        logic [2:0]  r;
        bit          found;
        if (n == 2) return 3'b011;
        for (int k = 0; k < 3; k++) t[k] = {cwe[i][k], caddr[i][k], cdata[i][k]};
        found = 0;
        maj   = '0;
        for (int j = 0; j < 3; j++)
            for (int k = j + 1; k < 3; k++)
                if (t[j] == t[k]) begin found = 1; maj = t[j]; end
        if (!found) return 3'b111;
        r = 3'b000;
        for (int k = 0; k < 3; k++) if (t[k] != maj) r[k] = 1'b1;
        return r;
    endfunction

    task automatic model_step(int i, int n);
        bit mm;
        mm = 0;
        case (m_phase[i])
            0: if (enable) begin
                for (int k = 1; k < n; k++) begin
                    if (cwe[i][k] != cwe[i][0]) mm = 1;
                    else if (cwe[i][0] && (caddr[i][k] != caddr[i][0] || cdata[i][k] != cdata[i][0])) mm = 1;
                end
                if (mm) begin
                    m_cnt[i]    = (m_cnt[i] < 255) ? m_cnt[i] + 1 : 255;
                    m_faulty[i] = m_faulty[i] | blame(i, n);
                    if (m_retry[i] == MAX_RETRY) m_phase[i] = 3;
                    else begin m_phase[i] = 1; m_retry[i]++; end
                end else if (commit) begin
                    m_ckpt[i]  = pc;
                    m_retry[i] = 0;
                end
            end
            1: m_phase[i] = 2;
            2: if (done) m_phase[i] = 0;
            default: ;
        endcase
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0; m_ckpt[i] = 32'h0; m_retry[i] = 0; m_cnt[i] = 0; m_faulty[i] = 3'b000;
        end
    endtask

    task automatic check_all();
        chk("reset_o[2c]",   32'(r2), 32'(m_phase[0] == 1));
        chk("recover_o[2c]", 32'(v2), 32'(m_phase[0] == 2));
        chk("error_o[2c]",   32'(e2), 32'(m_phase[0] == 3));
        chk("rec_pc[2c]",    p2,      m_ckpt[0]);
        chk("faulty_o[2c]",  32'(f2), 32'(m_faulty[0][1:0]));
        chk("err_count[2c]", 32'(c2), 32'(m_cnt[0]));
        chk("reset_o[3c]",   32'(r3), 32'(m_phase[1] == 1));
        chk("recover_o[3c]", 32'(v3), 32'(m_phase[1] == 2));
        chk("error_o[3c]",   32'(e3), 32'(m_phase[1] == 3));
        chk("rec_pc[3c]",    p3,      m_ckpt[1]);
        chk("faulty_o[3c]",  32'(f3), 32'(m_faulty[1]));
        chk("err_count[3c]", 32'(c3), 32'(m_cnt[1]));
    endtask

    task automatic step();
        model_step(0, 2);
        model_step(1, 3);
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Reset is dropped mid-cycle and checked before any clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    task automatic set_equal(int i, logic we, logic [5:0] a, logic [31:0] d);
        for (int k = 0; k < 3; k++) begin cwe[i][k] = we; caddr[i][k] = a; cdata[i][k] = d; end
    endtask

    initial begin
        rst_n = 1'b1; enable = 1'b0; commit = 1'b0; done = 1'b0; pc = 32'h0;
        set_equal(0, 1'b0, 6'h0, 32'h0);
        set_equal(1, 1'b0, 6'h0, 32'h0);
        model_reset();
        #3;
        do_reset();

        // Matching writes and a checkpoint
        enable = 1'b1;
        set_equal(0, 1'b1, 6'h0A, 32'h6);
        set_equal(1, 1'b1, 6'h0A, 32'h6);
        for (int c = 0; c < 10; c++) begin
            commit = (c == 4); pc = (c == 4) ? 32'h100 : 32'h0;
            step();
        end
        commit = 1'b0;
        chk("ckpt_100", p2, 32'h100);

        // Single data mismatch on the 2-core instance
        cdata[0][1] = 32'h7;
        commit = 1'b1; pc = 32'h200;
        step();
        chk("mm_reset_o", 32'(r2), 32'h1);
        commit = 1'b0;
        set_equal(0, 1'b1, 6'h0A, 32'h6);
        step();
        chk("mm_recover_o", 32'(v2), 32'h1);
        chk("mm_rec_pc", p2, 32'h100);
        chk("mm_faulty", 32'(f2), 32'h3);
        chk("mm_count", 32'(c2), 32'h1);
        step();
        done = 1'b1; step(); done = 1'b0;
        chk("done_run", 32'(v2), 32'h0);
        done = 1'b1; step(); step(); done = 1'b0;

        // Retry exhaustion leads to FAIL
        do_reset();
        commit = 1'b1; pc = 32'h40; step(); commit = 1'b0;
        for (int r = 0; r < 4; r++) begin
            cwe[0][0] = 1'b0;
            step();
            cwe[0][0] = 1'b1;
            if (r < 3) begin
                step();
                done = 1'b1; step(); done = 1'b0;
            end
        end
        chk("fail_error_o", 32'(e2), 32'h1);
        done = 1'b1; commit = 1'b1;
        for (int c = 0; c < 4; c++) step();
        done = 1'b0; commit = 1'b0;
        do_reset();

        // Majority voting on the 3-core instance
        caddr[1][2] = 6'h0B;
        step();
        set_equal(1, 1'b1, 6'h0A, 32'h6);
        chk("vote_100", 32'(f3), 32'h4);
        step();
        done = 1'b1; step(); done = 1'b0;
        do_reset();
        cdata[1][0] = 32'h1; cdata[1][1] = 32'h2; cdata[1][2] = 32'h3;
        step();
        set_equal(1, 1'b1, 6'h0A, 32'h6);
        chk("vote_111", 32'(f3), 32'h7);
        step();

        // Asynchronous reset in the middle of recovery
        commit = 1'b1; pc = 32'h300;
        step(); step(); done = 1'b1; step(); done = 1'b0; step();
        commit = 1'b0;
        cdata[0][0] = 32'h9;
        step();
        set_equal(0, 1'b1, 6'h0A, 32'h6);
        step();
        do_reset();
        chk("abort_pc", p2, 32'h0);

        // Error counter saturation
        for (int s = 0; s < 260; s++) begin
            cdata[0][1] = 32'hFF;
            step();
            cdata[0][1] = 32'h6;
            step();
            done = 1'b1; step(); done = 1'b0;
            commit = 1'b1; pc = s; step(); commit = 1'b0;
        end
        chk("count_sat", 32'(c2), 32'hFF);
        do_reset();

        // Random traffic
        for (int it = 0; it < 600; it++) begin
            enable = ($urandom % 8) != 0;
            commit = ($urandom % 3) == 0;
            done   = ($urandom % 3) == 0;
            pc     = $urandom;
            for (int i = 0; i < 2; i++) begin
                set_equal(i, 1'($urandom % 2), 6'($urandom % 4), 32'($urandom % 4));
                for (int f = 0; f < 2; f++) begin
                    if (($urandom % 5) == 0) begin
                        int k;
                        k = (i == 0) ? int'($urandom % 2) : int'($urandom % 3);
                        case ($urandom % 3)
                            0: cwe[i][k] = ~cwe[i][k];
                            1: caddr[i][k] = caddr[i][k] ^ 6'h1;
                            default: cdata[i][k] = cdata[i][k] ^ 32'h10;
                        endcase
                    end
                end
            end
            if (($urandom % 40) == 0) do_reset();
            else step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ft_lockstep_ctrl.md
FT_LOCKSTEP_CTRL -- requirements
Module: ft_lockstep_ctrl

Interface
REQ-001 Parameter NCORES, default 2, number of replicated cores compared (legal values 2 or 3).
REQ-002 Parameter ADDR_W, default 6, register-file write address width.
REQ-003 Parameter DATA_W, default 32, register-file write data width.
REQ-004 Parameter PC_W, default 32, program counter width.
REQ-005 Parameter CNT_W, default 8, error counter width.
REQ-006 Parameter MAX_RETRY, default 3, recoveries allowed without an intervening checkpoint.
REQ-007 Parameter RESET_PC, default 0, checkpoint value after reset.
REQ-008 clk_i  in  1  single clock; all state on rising edge.
REQ-009 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-010 enable_i  in  1  comparison enable.
REQ-011 we_i  in  NCORES  per-core register-file write enable.
REQ-012 addr_i  in  NCORES*ADDR_W  per-core write address, core k at slice k.
REQ-013 data_i  in  NCORES*DATA_W  per-core write data, core k at slice k.
REQ-014 pc_i  in  PC_W  retiring PC of core 0.
REQ-015 commit_i  in  1  pc_i valid, instruction retired.
REQ-016 done_i  in  1  cores finished restoring from checkpoint.
REQ-017 reset_o  out  1  core reset request.
REQ-018 recover_o  out  1  recovery in progress.
REQ-019 recovery_pc_o  out  PC_W  last checkpointed PC.
REQ-020 error_o  out  1  unrecoverable failure, sticky.
REQ-021 faulty_o  out  NCORES  sticky per-core dissent flags.
REQ-022 err_count_o  out  CNT_W  total mismatches detected.

Function
REQ-023 Mismatch (combinational) SHALL be 1 in RUN with enable_i=1 when any we_i bits differ, or all we_i=1 and any addr/data slice differs.
REQ-024 States SHALL be RUN, RST, RECOVER, FAIL; reset state RUN.
REQ-025 Mismatch in cycle N SHALL move the FSM to RST at N+1; reset_o=1 exactly while in RST (one cycle); RECOVER from N+2.
REQ-026 recover_o SHALL be 1 throughout RECOVER; done_i=1 in RECOVER SHALL return to RUN next cycle.
REQ-027 done_i outside RECOVER SHALL be ignored; mismatch outside RUN SHALL be ignored.
REQ-028 In RUN, commit_i=1 with enable_i=1 and no mismatch SHALL load pc_i into the checkpoint and clear the retry counter; commit during a mismatch cycle SHALL NOT update it.
REQ-029 recovery_pc_o SHALL equal the checkpoint register, stable during RST and RECOVER.
REQ-030 Each detected mismatch SHALL increment the retry counter and err_count_o; err_count_o saturates at all-ones.
REQ-031 A mismatch with retry counter already equal to MAX_RETRY SHALL go to FAIL instead of RST; FAIL asserts error_o, keeps reset_o=0, recover_o=0, and is left only by rst_ni.
REQ-032 NCORES=3: on mismatch, the core disagreeing with a 2-core majority (we, addr, data tuple) SHALL have its faulty_o bit set; no majority sets all bits.
REQ-033 NCORES=2: on mismatch both faulty_o bits SHALL be set.
REQ-034 enable_i=0 SHALL suppress comparison and checkpointing; FSM progress in RST/RECOVER continues.

Reset
REQ-035 rst_ni=0 SHALL immediately force state RUN, reset_o=0, recover_o=0, error_o=0, faulty_o=0, err_count_o=0, retry counter 0, recovery_pc_o=RESET_PC.
REQ-036 rst_ni asserted mid-recovery SHALL abort it with the same values; no pending request survives.

Verification
REQ-037 NCORES=2, both cores we=1 addr=6'h0A data=32'h6 over 10 cycles, commit with pc=32'h100 -> no reset_o, recovery_pc_o=32'h100, err_count_o=0.
REQ-038 Core1 data=32'h7 vs core0 32'h6 at cycle N -> reset_o=1 at N+1 only, recover_o=1 from N+2, recovery_pc_o=32'h100, err_count_o=1, faulty_o=2'b11.
REQ-039 In RECOVER assert done_i one cycle -> recover_o=0 and RUN next cycle; done_i pulsed in RUN -> no effect.
REQ-040 MAX_RETRY=3, four mismatches with no commit in between -> three recoveries, fourth enters FAIL, error_o=1 until rst_ni.
REQ-041 NCORES=3, core2 addr=6'h0B vs 6'h0A -> faulty_o=3'b100; all three data differ -> faulty_o=3'b111.
REQ-042 rst_ni low during RECOVER -> all outputs to reset values same cycle, recovery_pc_o=RESET_PC.
